// File: rtl/pipe_regfile_if.sv
// Bundles the register-file side of the pipeline: read ports, compare flags,
// write sources and the LM/SM streaming handshakes.
interface pipe_regfile_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    localparam int AW = $clog2(NREG);

    logic [DATA_W-1:0] pc;
    logic              pc_we;
    logic [AW-1:0]     ra_addr;
    logic [AW-1:0]     rb_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              cmp_eq;
    logic              cmp_lt;
    logic              cmp_le;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lnk_en;
    logic [AW-1:0]     lnk_addr;
    logic [DATA_W-1:0] lnk_data;
    logic              lm_start;
    logic [NREG-1:0]   lm_mask;
    logic              lm_valid;
    logic [DATA_W-1:0] lm_data;
    logic              lm_ready;
    logic              lm_busy;
    logic              lm_done;
    logic              sm_start;
    logic [NREG-1:0]   sm_mask;
    logic              sm_ready;
    logic              sm_valid;
    logic [DATA_W-1:0] sm_data;
    logic [AW-1:0]     sm_idx;
    logic              sm_busy;
    logic              sm_done;

    modport master (
        output pc, pc_we, ra_addr, rb_addr,
        output wb_en, wb_addr, wb_data, lnk_en, lnk_addr, lnk_data,
        output lm_start, lm_mask, lm_valid, lm_data,
        output sm_start, sm_mask, sm_ready,
        input  rd_a, rd_b, cmp_eq, cmp_lt, cmp_le,
        input  lm_ready, lm_busy, lm_done,
        input  sm_valid, sm_data, sm_idx, sm_busy, sm_done
    );

    modport slave (
        input  pc, pc_we, ra_addr, rb_addr,
        input  wb_en, wb_addr, wb_data, lnk_en, lnk_addr, lnk_data,
        input  lm_start, lm_mask, lm_valid, lm_data,
        input  sm_start, sm_mask, sm_ready,
        output rd_a, rd_b, cmp_eq, cmp_lt, cmp_le,
        output lm_ready, lm_busy, lm_done,
        output sm_valid, sm_data, sm_idx, sm_busy, sm_done
    );
endinterface

// File: rtl/pipe_regfile.sv
// Register file with bypassed registered reads, prioritised write sources,
// unsigned compare flags and multi-register load/store sequencers.
module pipe_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int PC_REG = 0
) (
    input  logic           clock,
    input  logic           reset_n,
    pipe_regfile_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [0:0] {LM_IDLE = 1'b0, LM_RUN = 1'b1} lm_state_t;
    typedef enum logic [0:0] {SM_IDLE = 1'b0, SM_RUN = 1'b1} sm_state_t;

    // Mask bit (NREG-1-i) names register i; flip so bit i names register i.
    function automatic logic [NREG-1:0] map_mask(input logic [NREG-1:0] m);
        logic [NREG-1:0] r;
        for (int i = 0; i < NREG; i++) begin
            r[i] = m[NREG-1-i];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] lowest_idx(input logic [NREG-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = NREG-1; i >= 0; i--) begin
            idx = v[i] ? AW'(i) : idx;
        end
        return idx;
    endfunction

    logic [DATA_W-1:0] regs_r   [NREG];
    logic [DATA_W-1:0] nxt_s    [NREG];
    logic [DATA_W-1:0] shadow_r [NREG];
    logic [DATA_W-1:0] rd_a_r;
    logic [DATA_W-1:0] rd_b_r;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;

    lm_state_t         lm_state_r;
    lm_state_t         lm_state_nxt_s;
    logic [NREG-1:0]   lm_pend_r;
    logic [NREG-1:0]   lm_pend_nxt_s;
    logic [NREG-1:0]   lm_rest_s;
    logic [AW-1:0]     lm_idx_s;
    logic              lm_wr_s;
    logic              lm_done_r;
    logic              lm_done_nxt_s;

    sm_state_t         sm_state_r;
    sm_state_t         sm_state_nxt_s;
    logic [NREG-1:0]   sm_pend_r;
    logic [NREG-1:0]   sm_pend_nxt_s;
    logic [NREG-1:0]   sm_start_pend_s;
    logic [NREG-1:0]   sm_rest_s;
    logic [AW-1:0]     sm_idx_r;
    logic [AW-1:0]     sm_idx_nxt_s;
    logic [DATA_W-1:0] sm_data_r;
    logic [DATA_W-1:0] sm_data_nxt_s;
    logic              sm_snap_s;
    logic              sm_done_r;
    logic              sm_done_nxt_s;

    assign lm_idx_s        = lowest_idx(lm_pend_r);
    assign lm_rest_s       = lm_pend_r & (lm_pend_r - NREG'(1));
    assign lm_wr_s         = (lm_state_r == LM_RUN) && bus.lm_valid;
    assign sm_start_pend_s = map_mask(bus.sm_mask);
    assign sm_rest_s       = sm_pend_r & (sm_pend_r - NREG'(1));

    // Per-register write arbitration: LM > write-back > link > PC mirror.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (lm_wr_s && (lm_idx_s == AW'(i))) begin
                nxt_s[i] = bus.lm_data;
            end else if (bus.wb_en && (bus.wb_addr == AW'(i))) begin
                nxt_s[i] = bus.wb_data;
            end else if (bus.lnk_en && (bus.lnk_addr == AW'(i))) begin
                nxt_s[i] = bus.lnk_data;
            end else if (bus.pc_we && (i == PC_REG)) begin
                nxt_s[i] = bus.pc;
            end else begin
                nxt_s[i] = regs_r[i];
            end
        end
    end

    // Register array; reset value of R[i] is i.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= DATA_W'(i);
            end
        end else begin
            regs_r <= nxt_s;
        end
    end

    // Read ports take the post-edge value so same-edge writes are bypassed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_a_r <= '0;
            rd_b_r <= '0;
        end else begin
            rd_a_r <= nxt_s[bus.ra_addr];
            rd_b_r <= nxt_s[bus.rb_addr];
        end
    end

    assign op_a_s     = regs_r[bus.ra_addr];
    assign op_b_s     = regs_r[bus.rb_addr];
    assign bus.cmp_eq = (op_a_s == op_b_s);
    assign bus.cmp_lt = (op_a_s <  op_b_s);
    assign bus.cmp_le = (op_a_s <= op_b_s);
    assign bus.rd_a   = rd_a_r;
    assign bus.rd_b   = rd_b_r;

    // LM next-state: consume one beat per valid cycle into the lowest pending register.
    always_comb begin
        lm_state_nxt_s = lm_state_r;
        lm_pend_nxt_s  = lm_pend_r;
        lm_done_nxt_s  = 1'b0;
        case (lm_state_r)
            LM_IDLE: begin
                if (bus.lm_start && (|bus.lm_mask)) begin
                    lm_pend_nxt_s  = map_mask(bus.lm_mask);
                    lm_state_nxt_s = LM_RUN;
                end else if (bus.lm_start) begin
                    lm_done_nxt_s  = 1'b1;
                end else begin
                    lm_done_nxt_s  = 1'b0;
                end
            end
            LM_RUN: begin
                if (bus.lm_valid) begin
                    lm_pend_nxt_s = lm_rest_s;
                    if (lm_rest_s == '0) begin
                        lm_state_nxt_s = LM_IDLE;
                        lm_done_nxt_s  = 1'b1;
                    end else begin
                        lm_state_nxt_s = LM_RUN;
                    end
                end else begin
                    lm_pend_nxt_s = lm_pend_r;
                end
            end
            default: begin
                lm_state_nxt_s = LM_IDLE;
                lm_pend_nxt_s  = '0;
            end
        endcase
    end

    // LM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lm_state_r <= LM_IDLE;
            lm_pend_r  <= '0;
            lm_done_r  <= 1'b0;
        end else begin
            lm_state_r <= lm_state_nxt_s;
            lm_pend_r  <= lm_pend_nxt_s;
            lm_done_r  <= lm_done_nxt_s;
        end
    end

    assign bus.lm_ready = (lm_state_r == LM_RUN);
    assign bus.lm_busy  = (lm_state_r == LM_RUN);
    assign bus.lm_done  = lm_done_r;

    // SM next-state: the presented entry is preloaded so it holds under backpressure.
    always_comb begin
        sm_state_nxt_s = sm_state_r;
        sm_pend_nxt_s  = sm_pend_r;
        sm_idx_nxt_s   = sm_idx_r;
        sm_data_nxt_s  = sm_data_r;
        sm_snap_s      = 1'b0;
        sm_done_nxt_s  = 1'b0;
        case (sm_state_r)
            SM_IDLE: begin
                if (bus.sm_start) begin
                    sm_snap_s = 1'b1;
                    if (|bus.sm_mask) begin
                        sm_pend_nxt_s  = sm_start_pend_s;
                        sm_idx_nxt_s   = lowest_idx(sm_start_pend_s);
                        sm_data_nxt_s  = regs_r[lowest_idx(sm_start_pend_s)];
                        sm_state_nxt_s = SM_RUN;
                    end else begin
                        sm_done_nxt_s  = 1'b1;
                    end
                end else begin
                    sm_snap_s = 1'b0;
                end
            end
            SM_RUN: begin
                if (bus.sm_ready) begin
                    sm_pend_nxt_s = sm_rest_s;
                    if (sm_rest_s == '0) begin
                        sm_state_nxt_s = SM_IDLE;
                        sm_idx_nxt_s   = '0;
                        sm_data_nxt_s  = '0;
                        sm_done_nxt_s  = 1'b1;
                    end else begin
                        sm_idx_nxt_s   = lowest_idx(sm_rest_s);
                        sm_data_nxt_s  = shadow_r[lowest_idx(sm_rest_s)];
                    end
                end else begin
                    sm_pend_nxt_s = sm_pend_r;
                end
            end
            default: begin
                sm_state_nxt_s = SM_IDLE;
                sm_pend_nxt_s  = '0;
            end
        endcase
    end

    // SM state and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sm_state_r <= SM_IDLE;
            sm_pend_r  <= '0;
            sm_idx_r   <= '0;
            sm_data_r  <= '0;
            sm_done_r  <= 1'b0;
        end else begin
            sm_state_r <= sm_state_nxt_s;
            sm_pend_r  <= sm_pend_nxt_s;
            sm_idx_r   <= sm_idx_nxt_s;
            sm_data_r  <= sm_data_nxt_s;
            sm_done_r  <= sm_done_nxt_s;
        end
    end

    // Shadow copy taken at SM start, isolating the stream from later writes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (sm_snap_s) begin
            shadow_r <= regs_r;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign bus.sm_valid = (sm_state_r == SM_RUN);
    assign bus.sm_busy  = (sm_state_r == SM_RUN);
    assign bus.sm_idx   = sm_idx_r;
    assign bus.sm_data  = sm_data_r;
    assign bus.sm_done  = sm_done_r;
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed-vector bench for pipe_regfile (DATA_W=16, NREG=8, PC_REG=0).
module tb_pipe_regfile;
    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;

    pipe_regfile_if #(.DATA_W(16), .NREG(8)) bus ();

    pipe_regfile #(.DATA_W(16), .NREG(8), .PC_REG(0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pc = 16'h0; bus.pc_we = 1'b0;
        bus.ra_addr = 3'd0; bus.rb_addr = 3'd0;
        bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 16'h0;
        bus.lnk_en = 1'b0; bus.lnk_addr = 3'd0; bus.lnk_data = 16'h0;
        bus.lm_start = 1'b0; bus.lm_mask = 8'h0; bus.lm_valid = 1'b0; bus.lm_data = 16'h0;
        bus.sm_start = 1'b0; bus.sm_mask = 8'h0; bus.sm_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.rd_a !== 16'h0) begin $display("FAIL reset_rd_a got %h want 0000", bus.rd_a); n_err++; end
        n_vec++; if (bus.rd_b !== 16'h0) begin $display("FAIL reset_rd_b got %h want 0000", bus.rd_b); n_err++; end
        n_vec++; if ({bus.lm_busy, bus.lm_ready, bus.lm_done} !== 3'b000) begin
            $display("FAIL reset_lm got %b want 000", {bus.lm_busy, bus.lm_ready, bus.lm_done}); n_err++; end
        n_vec++; if ({bus.sm_valid, bus.sm_busy, bus.sm_done} !== 3'b000) begin
            $display("FAIL reset_sm got %b want 000", {bus.sm_valid, bus.sm_busy, bus.sm_done}); n_err++; end
        n_vec++; if ({bus.sm_idx, bus.sm_data} !== 19'h0) begin
            $display("FAIL reset_sm_out got idx %0d data %h want 0/0000", bus.sm_idx, bus.sm_data); n_err++; end
    endtask

    task automatic test_read();
        bus.ra_addr = 3'd3; bus.rb_addr = 3'd5;
        #1;
        n_vec++; if ({bus.cmp_eq, bus.cmp_lt, bus.cmp_le} !== 3'b011) begin
            $display("FAIL cmp_3_5 got eq/lt/le %b want 011", {bus.cmp_eq, bus.cmp_lt, bus.cmp_le}); n_err++; end
        tick();
        n_vec++; if (bus.rd_a !== 16'h0003) begin $display("FAIL read_r3 got %h want 0003", bus.rd_a); n_err++; end
        n_vec++; if (bus.rd_b !== 16'h0005) begin $display("FAIL read_r5 got %h want 0005", bus.rd_b); n_err++; end
        bus.ra_addr = 3'd4; bus.rb_addr = 3'd4;
        #1;
        n_vec++; if ({bus.cmp_eq, bus.cmp_lt, bus.cmp_le} !== 3'b101) begin
            $display("FAIL cmp_4_4 got eq/lt/le %b want 101", {bus.cmp_eq, bus.cmp_lt, bus.cmp_le}); n_err++; end
        bus.ra_addr = 3'd6; bus.rb_addr = 3'd2;
        #1;
        n_vec++; if ({bus.cmp_eq, bus.cmp_lt, bus.cmp_le} !== 3'b000) begin
            $display("FAIL cmp_6_2 got eq/lt/le %b want 000", {bus.cmp_eq, bus.cmp_lt, bus.cmp_le}); n_err++; end
    endtask

    task automatic test_bypass_priority();
        bus.wb_en = 1'b1;  bus.wb_addr = 3'd2;  bus.wb_data = 16'h1234;
        bus.lnk_en = 1'b1; bus.lnk_addr = 3'd2; bus.lnk_data = 16'h5555;
        bus.ra_addr = 3'd2; bus.rb_addr = 3'd7;
        tick();
        n_vec++; if (bus.rd_a !== 16'h1234) begin $display("FAIL bypass_wb_over_lnk got %h want 1234", bus.rd_a); n_err++; end
        // Unsigned compare with the top bit set: 0xF000 vs R2=0x1234.
        bus.wb_addr = 3'd3; bus.wb_data = 16'hF000;
        bus.lnk_addr = 3'd4; bus.lnk_data = 16'h2222;
        bus.ra_addr = 3'd3; bus.rb_addr = 3'd4;
        tick();
        bus.wb_en = 1'b0; bus.lnk_en = 1'b0;
        n_vec++; if ({bus.rd_a, bus.rd_b} !== {16'hF000, 16'h2222}) begin
            $display("FAIL split_writes got %h/%h want F000/2222", bus.rd_a, bus.rd_b); n_err++; end
        bus.ra_addr = 3'd3; bus.rb_addr = 3'd2;
        #1;
        n_vec++; if ({bus.cmp_eq, bus.cmp_lt, bus.cmp_le} !== 3'b000) begin
            $display("FAIL cmp_unsigned got eq/lt/le %b want 000", {bus.cmp_eq, bus.cmp_lt, bus.cmp_le}); n_err++; end
        bus.ra_addr = 3'd2;
        tick();
        n_vec++; if (bus.rd_a !== 16'h1234) begin $display("FAIL r2_held got %h want 1234", bus.rd_a); n_err++; end
    endtask

    task automatic test_pc_mirror();
        bus.pc_we = 1'b1; bus.pc = 16'h0040;
        bus.wb_en = 1'b1; bus.wb_addr = 3'd0; bus.wb_data = 16'h00AA;
        bus.ra_addr = 3'd0;
        tick();
        bus.wb_en = 1'b0;
        n_vec++; if (bus.rd_a !== 16'h00AA) begin $display("FAIL wb_over_pc got %h want 00AA", bus.rd_a); n_err++; end
        tick();
        n_vec++; if (bus.rd_a !== 16'h0040) begin $display("FAIL pc_mirror got %h want 0040", bus.rd_a); n_err++; end
        bus.lnk_en = 1'b1; bus.lnk_addr = 3'd0; bus.lnk_data = 16'h0BEE; bus.pc = 16'h0044;
        tick();
        bus.lnk_en = 1'b0; bus.pc_we = 1'b0;
        n_vec++; if (bus.rd_a !== 16'h0BEE) begin $display("FAIL lnk_over_pc got %h want 0BEE", bus.rd_a); n_err++; end
    endtask

    task automatic test_lm_stall();
        logic        vv [5];
        logic [15:0] dd [5];
        vv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        dd = '{16'h000A, 16'h0000, 16'h0000, 16'h000B, 16'h000C};
        bus.lm_start = 1'b1; bus.lm_mask = 8'b1010_0001;
        tick();
        bus.lm_start = 1'b0; bus.lm_mask = 8'h0;
        for (int k = 0; k < 5; k++) begin
            bus.lm_valid = vv[k]; bus.lm_data = dd[k];
            #1;
            n_vec++; if ({bus.lm_busy, bus.lm_ready, bus.lm_done} !== 3'b110) begin
                $display("FAIL lm_run_cyc%0d got busy/ready/done %b want 110", k,
                         {bus.lm_busy, bus.lm_ready, bus.lm_done}); n_err++; end
            tick();
        end
        bus.lm_valid = 1'b0;
        n_vec++; if ({bus.lm_busy, bus.lm_done} !== 2'b01) begin
            $display("FAIL lm_done_pulse got busy/done %b want 01", {bus.lm_busy, bus.lm_done}); n_err++; end
        bus.ra_addr = 3'd0; bus.rb_addr = 3'd2;
        tick();
        n_vec++; if (bus.lm_done !== 1'b0) begin $display("FAIL lm_done_single got %b want 0", bus.lm_done); n_err++; end
        n_vec++; if ({bus.rd_a, bus.rd_b} !== {16'h000A, 16'h000B}) begin
            $display("FAIL lm_r0_r2 got %h/%h want 000A/000B", bus.rd_a, bus.rd_b); n_err++; end
        bus.ra_addr = 3'd7; bus.rb_addr = 3'd1;
        tick();
        n_vec++; if ({bus.rd_a, bus.rd_b} !== {16'h000C, 16'h0001}) begin
            $display("FAIL lm_r7_r1 got %h/%h want 000C/0001", bus.rd_a, bus.rd_b); n_err++; end
    endtask

    task automatic test_sm_backpressure();
        do_reset();
        bus.sm_start = 1'b1; bus.sm_mask = 8'b0100_0010; bus.sm_ready = 1'b0;
        tick();
        bus.sm_start = 1'b0; bus.sm_mask = 8'h0;
        n_vec++; if ({bus.sm_valid, bus.sm_busy, bus.sm_idx, bus.sm_data} !== {2'b11, 3'd1, 16'h0001}) begin
            $display("FAIL sm_first got v%b idx %0d data %h want v1 idx 1 data 0001",
                     bus.sm_valid, bus.sm_idx, bus.sm_data); n_err++; end
        for (int k = 0; k < 3; k++) begin
            bus.wb_en = (k == 0); bus.wb_addr = 3'd1; bus.wb_data = 16'hFFFF;
            tick();
            bus.wb_en = 1'b0;
            n_vec++; if ({bus.sm_valid, bus.sm_idx, bus.sm_data} !== {1'b1, 3'd1, 16'h0001}) begin
                $display("FAIL sm_stall%0d got v%b idx %0d data %h want v1 idx 1 data 0001",
                         k, bus.sm_valid, bus.sm_idx, bus.sm_data); n_err++; end
        end
        bus.sm_ready = 1'b1;
        tick();
        n_vec++; if ({bus.sm_valid, bus.sm_idx, bus.sm_data, bus.sm_done} !== {1'b1, 3'd6, 16'h0006, 1'b0}) begin
            $display("FAIL sm_second got v%b idx %0d data %h done %b want v1 idx 6 data 0006 done 0",
                     bus.sm_valid, bus.sm_idx, bus.sm_data, bus.sm_done); n_err++; end
        tick();
        bus.sm_ready = 1'b0;
        n_vec++; if ({bus.sm_valid, bus.sm_busy, bus.sm_done} !== 3'b001) begin
            $display("FAIL sm_done_pulse got valid/busy/done %b want 001",
                     {bus.sm_valid, bus.sm_busy, bus.sm_done}); n_err++; end
        bus.ra_addr = 3'd1;
        tick();
        n_vec++; if (bus.sm_done !== 1'b0) begin $display("FAIL sm_done_single got %b want 0", bus.sm_done); n_err++; end
        n_vec++; if (bus.rd_a !== 16'hFFFF) begin $display("FAIL sm_r1_written got %h want FFFF", bus.rd_a); n_err++; end
    endtask

    task automatic test_abort_zero();
        bus.lm_start = 1'b1; bus.lm_mask = 8'b1100_0000;
        tick();
        bus.lm_start = 1'b0; bus.lm_mask = 8'h0;
        bus.lm_valid = 1'b1; bus.lm_data = 16'h0077;
        tick();
        bus.lm_valid = 1'b0;
        n_vec++; if (bus.lm_busy !== 1'b1) begin $display("FAIL abort_midrun_busy got %b want 1", bus.lm_busy); n_err++; end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_vec++; if ({bus.lm_busy, bus.lm_done} !== 2'b00) begin
            $display("FAIL abort_state got busy/done %b want 00", {bus.lm_busy, bus.lm_done}); n_err++; end
        bus.ra_addr = 3'd0; bus.rb_addr = 3'd1;
        tick();
        n_vec++; if (bus.lm_done !== 1'b0) begin $display("FAIL abort_no_done got %b want 0", bus.lm_done); n_err++; end
        n_vec++; if ({bus.rd_a, bus.rd_b} !== {16'h0000, 16'h0001}) begin
            $display("FAIL abort_regs got %h/%h want 0000/0001", bus.rd_a, bus.rd_b); n_err++; end
        bus.lm_start = 1'b1; bus.lm_mask = 8'h00; bus.lm_valid = 1'b1; bus.lm_data = 16'hDEAD;
        bus.sm_start = 1'b1; bus.sm_mask = 8'h00;
        tick();
        bus.lm_start = 1'b0; bus.lm_valid = 1'b0; bus.sm_start = 1'b0;
        n_vec++; if ({bus.lm_busy, bus.lm_done} !== 2'b01) begin
            $display("FAIL lm_zero_mask got busy/done %b want 01", {bus.lm_busy, bus.lm_done}); n_err++; end
        n_vec++; if ({bus.sm_valid, bus.sm_done} !== 2'b01) begin
            $display("FAIL sm_zero_mask got valid/done %b want 01", {bus.sm_valid, bus.sm_done}); n_err++; end
        bus.ra_addr = 3'd0; bus.rb_addr = 3'd7;
        tick();
        n_vec++; if ({bus.lm_done, bus.sm_done} !== 2'b00) begin
            $display("FAIL zero_mask_single got lm/sm done %b want 00", {bus.lm_done, bus.sm_done}); n_err++; end
        n_vec++; if ({bus.rd_a, bus.rd_b} !== {16'h0000, 16'h0007}) begin
            $display("FAIL zero_mask_no_write got %h/%h want 0000/0007", bus.rd_a, bus.rd_b); n_err++; end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_read();
        test_bypass_priority();
        test_pc_mirror();
        test_lm_stall();
        test_sm_backpressure();
        test_abort_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
